// File: rtl/ysyx_23060025_icache.sv
// Direct-mapped blocking instruction cache between the IFU fetch port and an
// AXI4-style burst read channel. One fetch in flight; whole-cache invalidate
// for fence.i. state_o exposes the FSM state for debug and checkers.
//
// Handshakes: the IFU holds psel and a stable paddr until the single-cycle
// pready pulse; psel is only sampled in IDLE. On the memory side an AR
// transfer happens on an edge where arvalid & arready are both high (arvalid
// and araddr hold until then), and an R beat is taken on an edge where
// rvalid & rready are both high.
module ysyx_23060025_icache #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ifu_psel_i,
  input  logic [ADDR_WIDTH-1:0] ifu_paddr_i,
  output logic                  ifu_pready_o,
  output logic [DATA_WIDTH-1:0] ifu_prdata_o,
  input  logic                  fencei_i,
  output logic                  mem_arvalid_o,
  input  logic                  mem_arready_i,
  output logic [ADDR_WIDTH-1:0] mem_araddr_o,
  output logic [7:0]            mem_arlen_o,
  output logic [2:0]            mem_arsize_o,
  output logic [1:0]            mem_arburst_o,
  input  logic                  mem_rvalid_i,
  output logic                  mem_rready_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic [1:0]            mem_rresp_i,
  input  logic                  mem_rlast_i,
  output logic [2:0]            state_o
);

  localparam int WB  = $clog2(LINE_WORDS);
  localparam int OFS = 2 + WB;
  localparam int IDX = $clog2(SETS);
  localparam int TAG = ADDR_WIDTH - IDX - OFS;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOOKUP  = 3'd1;
  localparam logic [2:0] S_MISS_AR = 3'd2;
  localparam logic [2:0] S_MISS_R  = 3'd3;
  localparam logic [2:0] S_RESP    = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:2] req_addr_q;
  logic [WB-1:0]         beat_cnt_q;
  logic                  err_q;
  logic                  fence_pend_q;
  logic [SETS-1:0]       valid_q;
  logic [TAG-1:0]        tag_q  [SETS];
  logic [DATA_WIDTH-1:0] data_q [SETS][LINE_WORDS];

  // Byte offset within a word is irrelevant to an instruction fetch.
  logic unused_paddr_lsb;
  assign unused_paddr_lsb = ^ifu_paddr_i[1:0];

  logic [TAG-1:0] req_tag;
  logic [IDX-1:0] req_idx;
  logic [WB-1:0]  req_word;
  assign req_tag  = req_addr_q[ADDR_WIDTH-1 -: TAG];
  assign req_idx  = req_addr_q[OFS +: IDX];
  assign req_word = req_addr_q[2 +: WB];

  logic hit, ar_hs, beat_hs, last_hs, err_next, full_line, line_ok;
  assign hit       = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign ar_hs     = (state_q == S_MISS_AR) && mem_arready_i;
  assign beat_hs   = (state_q == S_MISS_R) && mem_rvalid_i;
  assign last_hs   = beat_hs && mem_rlast_i;
  assign err_next  = err_q | (beat_hs && (mem_rresp_i != 2'b00));
  // A burst that ends before the last word is short and cannot be trusted.
  assign full_line = (beat_cnt_q == WB'(LINE_WORDS - 1));
  // A fence seen at any point during the refill keeps the new line invalid.
  assign line_ok   = ~err_next & ~fence_pend_q & ~fencei_i & full_line;

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (ifu_psel_i) state_d = S_LOOKUP;
      S_LOOKUP:  state_d = hit ? S_IDLE : S_MISS_AR;
      S_MISS_AR: if (ar_hs) state_d = S_MISS_R;
      S_MISS_R:  if (last_hs) state_d = S_RESP;
      S_RESP:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Control state, request latch, refill bookkeeping and valid bits.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      req_addr_q   <= '0;
      beat_cnt_q   <= '0;
      err_q        <= 1'b0;
      fence_pend_q <= 1'b0;
      valid_q      <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && ifu_psel_i) req_addr_q <= ifu_paddr_i[ADDR_WIDTH-1:2];
      if (ar_hs) begin
        beat_cnt_q <= '0;
        err_q      <= 1'b0;
      end else if (beat_hs) begin
        beat_cnt_q <= beat_cnt_q + WB'(1);
        err_q      <= err_next;
      end
      if (state_q == S_IDLE) fence_pend_q <= 1'b0;
      else if (fencei_i)     fence_pend_q <= 1'b1;
      if (state_q == S_IDLE && (fencei_i || fence_pend_q)) valid_q <= '0;
      else if (last_hs)                                   valid_q[req_idx] <= line_ok;
    end
  end

  // Line storage: beat data and tag are written during refill.
  always_ff @(posedge clock) begin
    if (!reset && beat_hs) data_q[req_idx][beat_cnt_q] <= mem_rdata_i;
    if (!reset && last_hs) tag_q[req_idx] <= req_tag;
  end

  // Outputs; reset forces every response/request strobe low at once.
  always_comb begin
    ifu_pready_o  = ~reset & (((state_q == S_LOOKUP) & hit) | (state_q == S_RESP));
    ifu_prdata_o  = '0;
    if (ifu_pready_o && !((state_q == S_RESP) && err_q)) ifu_prdata_o = data_q[req_idx][req_word];
    mem_arvalid_o = ~reset & (state_q == S_MISS_AR);
    mem_araddr_o  = '0;
    if (mem_arvalid_o) mem_araddr_o = {req_addr_q[ADDR_WIDTH-1:OFS], {OFS{1'b0}}};
    mem_rready_o  = ~reset & (state_q == S_MISS_R);
    mem_arlen_o   = 8'(LINE_WORDS - 1);
    mem_arsize_o  = 3'b010;
    mem_arburst_o = 2'b01;
    state_o       = state_q;
  end

endmodule

// File: tb/tb_ysyx_23060025_icache.sv
// Directed bench for ysyx_23060025_icache: fetch driver, AXI read memory
// model with stall/gap/error knobs, and a pready scoreboard monitor.
module tb_ysyx_23060025_icache;

  logic        clock = 1'b0;
  logic        reset;
  logic        ifu_psel_i;
  logic [31:0] ifu_paddr_i;
  logic        ifu_pready_o;
  logic [31:0] ifu_prdata_o;
  logic        fencei_i;
  logic        mem_arvalid_o;
  logic        mem_arready_i;
  logic [31:0] mem_araddr_o;
  logic [7:0]  mem_arlen_o;
  logic [2:0]  mem_arsize_o;
  logic [1:0]  mem_arburst_o;
  logic        mem_rvalid_i;
  logic        mem_rready_o;
  logic [31:0] mem_rdata_i;
  logic [1:0]  mem_rresp_i;
  logic        mem_rlast_i;
  logic [2:0]  state_o;

  ysyx_23060025_icache dut (
    .clock(clock), .reset(reset),
    .ifu_psel_i(ifu_psel_i), .ifu_paddr_i(ifu_paddr_i),
    .ifu_pready_o(ifu_pready_o), .ifu_prdata_o(ifu_prdata_o),
    .fencei_i(fencei_i),
    .mem_arvalid_o(mem_arvalid_o), .mem_arready_i(mem_arready_i),
    .mem_araddr_o(mem_araddr_o), .mem_arlen_o(mem_arlen_o),
    .mem_arsize_o(mem_arsize_o), .mem_arburst_o(mem_arburst_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rready_o(mem_rready_o),
    .mem_rdata_i(mem_rdata_i), .mem_rresp_i(mem_rresp_i),
    .mem_rlast_i(mem_rlast_i), .state_o(state_o)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- scoreboard state ----------------
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] ar_exp_q[$];

  // memory model knobs and counters
  int ar_stall  = 0;
  bit r_gap     = 1'b0;
  int err_beat  = -1;
  int beats_acc = 0;
  int ar_hs_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] info);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got %h expected none", name, info);
  endtask

  // Memory contents: line 0x3000_0000 holds 0x11..0x44, elsewhere addr^0xA5A5_0000.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[31:4] == 28'h3000000) begin
      case (a[3:2])
        2'd0:    return 32'h11;
        2'd1:    return 32'h22;
        2'd2:    return 32'h33;
        default: return 32'h44;
      endcase
    end
    return a ^ 32'hA5A5_0000;
  endfunction

  // ---------------- AXI read memory model (acts on negedges) ----------------
  initial begin
    int          m_st;
    int          stall;
    int          beat;
    logic [31:0] base;
    logic [31:0] ar_first;
    logic        acc;
    m_st = 0; stall = 0; beat = 0; base = '0; ar_first = '0;
    mem_arready_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    mem_rresp_i = 2'b00; mem_rlast_i = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        mem_arready_i = 1'b0; mem_rvalid_i = 1'b0; mem_rlast_i = 1'b0;
        m_st = 0; stall = 0;
      end else if (m_st == 0) begin
        if (mem_arvalid_o) begin
          if (stall == 0) ar_first = mem_araddr_o;
          else check("araddr_stable", mem_araddr_o, ar_first);
          if (stall < ar_stall) stall++;
          else begin
            mem_arready_i = 1'b1;
            m_st = 1; stall = 0;
            base = mem_araddr_o;
            if (ar_exp_q.size() == 0) fail_now("ar_unexpected", mem_araddr_o);
            else check("araddr", mem_araddr_o, ar_exp_q.pop_front());
            check("arlen", {24'h0, mem_arlen_o}, 32'd3);
            check("arsize_arburst", {27'h0, mem_arsize_o, mem_arburst_o}, {27'h0, 3'b010, 2'b01});
            ar_hs_cnt++;
          end
        end
      end else begin
        acc = 1'b0;
        if (m_st == 1) begin
          mem_arready_i = 1'b0;
          beat = 0;
          m_st = 2;
        end else if (mem_rvalid_i) begin
          acc = 1'b1;
          beat++; beats_acc++;
          mem_rvalid_i = 1'b0; mem_rlast_i = 1'b0;
        end
        if (beat == 4) m_st = 0;
        else if (!(r_gap && acc)) begin
          mem_rvalid_i = 1'b1;
          mem_rdata_i  = mem_word(base + 32'(4 * beat));
          mem_rresp_i  = (beat == err_beat) ? 2'b10 : 2'b00;
          mem_rlast_i  = (beat == 3);
        end
      end
    end
  end

  // ---------------- response monitor ----------------
  initial begin
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (ifu_pready_o) begin
          check("pready_single_cycle", {31'h0, prev}, 32'h0);
          if (exp_q.size() == 0) fail_now("prdata_unexpected", ifu_prdata_o);
          else check("prdata", ifu_prdata_o, exp_q.pop_front());
        end else begin
          check("prdata_zero_when_idle", ifu_prdata_o, 32'h0);
        end
      end
      prev = ifu_pready_o;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic fetch(input logic [31:0] addr, input logic [31:0] exp_data,
                       input bit refill, input bit fence_mid);
    int ar0;
    int ar_first;
    bit fenced;
    bit got;
    exp_q.push_back(exp_data);
    if (refill) ar_exp_q.push_back({addr[31:4], 4'h0});
    ar0 = ar_hs_cnt; ar_first = -1; fenced = 1'b0; got = 1'b0;
    @(posedge clock); #1;
    ifu_psel_i  = 1'b1;
    ifu_paddr_i = addr;
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clock);
      if (fence_mid) begin
        if (!fenced && state_o == 3'd3) begin
          fencei_i = 1'b1;
          fenced = 1'b1;
        end else fencei_i = 1'b0;
      end
      if (mem_arvalid_o && ar_first < 0) ar_first = k;
      if (ifu_pready_o) begin
        got = 1'b1;
        if (!refill) check("hit_latency", 32'(k), 32'd1);
      end
    end
    fencei_i = 1'b0;
    if (!got) fail_now("fetch_timeout", addr);
    if (refill) begin
      check("miss_ar_latency", 32'(ar_first), 32'd2);
      check("refill_count", 32'(ar_hs_cnt - ar0), 32'd1);
    end else begin
      check("hit_no_ar", 32'(ar_hs_cnt - ar0), 32'd0);
    end
    if (fence_mid) check("fence_in_miss_r", {31'h0, fenced}, 32'd1);
    @(posedge clock); #1;
    ifu_psel_i = 1'b0;
  endtask

  task automatic fence_idle();
    @(posedge clock); #1;
    fencei_i = 1'b1;
    @(posedge clock); #1;
    fencei_i = 1'b0;
  endtask

  // Start a refill and assert reset once two beats have been taken.
  task automatic fetch_reset(input logic [31:0] addr);
    int b0;
    bit seen;
    ar_exp_q.push_back({addr[31:4], 4'h0});
    b0 = beats_acc; seen = 1'b0;
    @(posedge clock); #1;
    ifu_psel_i  = 1'b1;
    ifu_paddr_i = addr;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge clock); #1;
      if (beats_acc - b0 >= 2) seen = 1'b1;
    end
    if (!seen) fail_now("reset_wait_timeout", addr);
    check("state_before_reset", {29'h0, state_o}, 32'd3);
    reset = 1'b1;
    ifu_psel_i = 1'b0;
    @(negedge clock);
    check("rst_mid_pready",  {31'h0, ifu_pready_o},  32'h0);
    check("rst_mid_prdata",  ifu_prdata_o,           32'h0);
    check("rst_mid_arvalid", {31'h0, mem_arvalid_o}, 32'h0);
    check("rst_mid_rready",  {31'h0, mem_rready_o},  32'h0);
    check("rst_mid_araddr",  mem_araddr_o,           32'h0);
    check("rst_mid_state",   {29'h0, state_o},       32'h0);
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b1; ifu_psel_i = 1'b0; ifu_paddr_i = '0; fencei_i = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_pready",  {31'h0, ifu_pready_o},  32'h0);
    check("rst_prdata",  ifu_prdata_o,           32'h0);
    check("rst_arvalid", {31'h0, mem_arvalid_o}, 32'h0);
    check("rst_rready",  {31'h0, mem_rready_o},  32'h0);
    check("rst_araddr",  mem_araddr_o,           32'h0);
    check("rst_state",   {29'h0, state_o},       32'h0);
    @(posedge clock); #1;
    reset = 1'b0;

    // cold miss then hit in the same line
    fetch(32'h3000_0004, 32'h0000_0022, 1'b1, 1'b0);
    fetch(32'h3000_000C, 32'h0000_0044, 1'b0, 1'b0);
    // conflict on index 0
    fetch(32'h3000_0100, 32'h95A5_0100, 1'b1, 1'b0);
    fetch(32'h3000_0000, 32'h0000_0011, 1'b1, 1'b0);
    // AR and R backpressure, then hits prove all four beats landed
    ar_stall = 5; r_gap = 1'b1;
    fetch(32'h3000_0208, 32'h95A5_0208, 1'b1, 1'b0);
    ar_stall = 0; r_gap = 1'b0;
    fetch(32'h3000_0204, 32'h95A5_0204, 1'b0, 1'b0);
    fetch(32'h3000_020C, 32'h95A5_020C, 1'b0, 1'b0);
    fetch(32'h3000_0200, 32'h95A5_0200, 1'b0, 1'b0);
    // error response on beat 1: zero word, line stays invalid
    err_beat = 1;
    fetch(32'h3000_0304, 32'h0000_0000, 1'b1, 1'b0);
    err_beat = -1;
    fetch(32'h3000_0304, 32'h95A5_0304, 1'b1, 1'b0);
    // fence.i during refill: data returned, line not kept
    fetch(32'h3000_0000, 32'h0000_0011, 1'b1, 1'b1);
    fetch(32'h3000_0008, 32'h0000_0033, 1'b1, 1'b0);
    fetch(32'h3000_0004, 32'h0000_0022, 1'b0, 1'b0);
    // fence.i while idle
    fence_idle();
    fetch(32'h3000_0004, 32'h0000_0022, 1'b1, 1'b0);
    // reset in the middle of a refill, then a clean refill
    fetch_reset(32'h3000_0040);
    fetch(32'h3000_0040, 32'h95A5_0040, 1'b1, 1'b0);
    fetch(32'h3000_0044, 32'h95A5_0044, 1'b0, 1'b0);

    repeat (5) @(posedge clock);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("ar_q_drained",  32'(ar_exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ysyx_23060025_icache.md
# ysyx_23060025_icache

Direct-mapped, blocking instruction cache that answers the IFU fetch request interface (psel/paddr in, pready/prdata out) and refills lines from the memory side over an AXI4-style burst read channel. It sits between the IFU stage and the SoC memory crossbar. It services one outstanding fetch at a time and supports a whole-cache invalidate for fence.i.

## Interface
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, instruction/beat width.
- LINE_WORDS, 4, words per line (power of two, ≥2); offset bits OFS = 2 + log2(LINE_WORDS).
- SETS, 16, number of lines (power of two); index bits IDX = log2(SETS); tag bits TAG = ADDR_WIDTH − IDX − OFS.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- ifu_psel_i  in  1  fetch request; held high, with a stable address, until the cycle pready is returned.
- ifu_paddr_i  in  ADDR_WIDTH  fetch address; bits [1:0] are ignored.
- ifu_pready_o  out  1  single-cycle pulse: prdata is valid this cycle.
- ifu_prdata_o  out  DATA_WIDTH  fetched instruction word.
- fencei_i  in  1  invalidate all lines (pulse).
- mem_arvalid_o  out  1  read address valid.
- mem_arready_i  in  1  read address accepted.
- mem_araddr_o  out  ADDR_WIDTH  line-aligned refill address.
- mem_arlen_o  out  8  burst length, LINE_WORDS−1.
- mem_arsize_o  out  3  constant 3'b010 (4 bytes).
- mem_arburst_o  out  2  constant 2'b01 (INCR).
- mem_rvalid_i  in  1  read beat valid.
- mem_rready_o  out  1  beat accept.
- mem_rdata_i  in  DATA_WIDTH  beat data.
- mem_rresp_i  in  2  beat response; nonzero means error.
- mem_rlast_i  in  1  final beat.

## Operation
- Storage: data array SETS×LINE_WORDS words, tag array SETS×TAG, valid array SETS×1 (registers).
- The address is split as tag = paddr[31 -: TAG], index = paddr[OFS +: IDX], word = paddr[2 +: log2(LINE_WORDS)].
- The FSM has the states IDLE, LOOKUP, MISS_AR, MISS_R and RESP.
- IDLE: on psel, latch paddr into req_addr and go to LOOKUP. psel is sampled only in IDLE.
- LOOKUP, hit (valid & tag match):
  - ifu_pready_o = 1 and ifu_prdata_o = data[index][word] in this cycle.
  - Next state IDLE.
- LOOKUP, miss: go to MISS_AR.
- MISS_AR:
  - mem_arvalid_o = 1, with araddr = {req_addr[31:OFS], OFS'b0}.
  - Go to MISS_R when arready is seen in the same cycle. arvalid stays high until then, and the AR fields stay stable.
- MISS_R:
  - mem_rready_o = 1.
  - Each accepted beat writes data[index][beat_cnt] and increments beat_cnt (log2(LINE_WORDS) bits, cleared on entering MISS_R).
  - Any nonzero rresp sets err_flag.
  - On the beat with rlast: tag[index] ← req tag, valid[index] ← ~err_flag_next & ~fence_pending; then go to RESP.
  - An early rlast ends the burst; the line is marked invalid.
- RESP: ifu_pready_o = 1 and next state IDLE.
  - ifu_prdata_o = data[index][word] (word now filled).
  - If err_flag is set, ifu_prdata_o = 32'h0000_0000 instead, so the IFU flags the instruction as invalid.
- fencei_i:
  - In IDLE: clear all valid bits at the next edge. A psel in the same cycle is still latched, and its lookup sees the cleared array.
  - In any other state: set fence_pending. The clear is applied on the first IDLE cycle and fence_pending then drops.
  - A line refilled while fence_pending is set is written invalid.
- ifu_prdata_o is 0 whenever ifu_pready_o = 0.

## Timing
- Reset values: FSM IDLE; all valid bits 0; beat_cnt, err_flag and fence_pending 0.
- Outputs during reset: ifu_pready_o=0, ifu_prdata_o=0, mem_arvalid_o=0, mem_rready_o=0, mem_araddr_o=0.
- Hit latency: psel is first high in cycle N, and pready pulses in cycle N+1.
- Miss latency: N+2 is the first arvalid cycle. pready comes 1 cycle after the rlast beat is accepted.
- pready is high for exactly one cycle per request. The IFU may drop psel combinationally in that cycle, and the cache must not depend on psel outside IDLE.
- Back-to-back requests: after pready, the next psel is sampled in the following cycle (IDLE). There is a minimum 1 idle cycle between responses.
- Reset asserted mid-refill: the FSM aborts to IDLE and arvalid/rready drop immediately. Residual memory beats are the interconnect's responsibility.

## Test plan
- Cold miss, then hit:
  - Stimulus: psel with paddr=0x3000_0004 against a memory model returning 0x11,0x22,0x33,0x44 for 0x3000_0000..C.
  - Required: AR shows araddr=0x3000_0000, arlen=3, and pready returns prdata=0x22.
  - Stimulus: a second request to 0x3000_000C.
  - Required: pready at N+1 with 0x44 and no AR traffic.
- Conflict miss:
  - Stimulus: 0x3000_0000 then 0x3000_0100 (same index 0, different tag), then 0x3000_0000 again.
  - Required: three refills, correct data each time.
- Backpressure: arready held low 5 cycles and rvalid gapped every other cycle → araddr stable while arvalid, all 4 beats captured, single pready.
- Error beat: rresp=2'b10 on beat 1 → prdata=0x0000_0000, and a re-fetch of the same address issues a new AR (line invalid).
- fence.i:
  - Stimulus: fencei during MISS_R for 0x3000_0000.
  - Required: the refill completes and pready returns the data; a later fetch to that line misses.
  - Stimulus: fencei in IDLE after a filled line.
  - Required: the next fetch misses.
- Reset in MISS_R after 2 beats → outputs return to their reset values on the next cycle, and a subsequent fetch to the same address misses and refills cleanly.
